// File: rtl/seven_segment_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver with frame-synchronous double buffering.
// Optional leading-zero blanking is enabled by defining SEVSEG_LZB_EN.
module seven_segment_scan_driver #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    pending,
    output logic                    frame_done
);

    localparam int unsigned VAL_W = 4 * NUM_DIGITS;
    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]      pre_cnt_q, pre_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VAL_W-1:0]      shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0] shadow_en_q, shadow_en_d;
    logic [VAL_W-1:0]      active_val_q, active_val_d;
    logic [NUM_DIGITS-1:0] active_en_q, active_en_d;
    logic                  pending_q, pending_d;
    logic                  frame_done_q, frame_done_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic                  tick_c;
    logic                  boundary_c;
    logic [NUM_DIGITS-1:0] lz_blank_c;
    logic [3:0]            cur_nib_c;
    logic                  cur_blank_c;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // Leading-zero mask: digit i > 0 blanks when it and every higher nibble are zero.
    always_comb begin
        lz_blank_c = '0;
`ifdef SEVSEG_LZB_EN
        begin
            logic zero_above;
            zero_above = 1'b1;
            for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
                zero_above    = zero_above && (active_val_q[4*i +: 4] == 4'h0);
                lz_blank_c[i] = (i > 0) && zero_above;
            end
        end
`endif
    end

    // Select the nibble and blanking state of the digit currently being scanned.
    always_comb begin
        cur_nib_c   = 4'h0;
        cur_blank_c = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib_c   = active_val_q[4*i +: 4];
                cur_blank_c = !active_en_q[i] || lz_blank_c[i];
            end
        end
    end

    always_comb begin
        pre_cnt_d    = pre_cnt_q;
        idx_d        = idx_q;
        shadow_val_d = shadow_val_q;
        shadow_en_d  = shadow_en_q;
        active_val_d = active_val_q;
        active_en_d  = active_en_q;
        pending_d    = pending_q;

        tick_c       = (pre_cnt_q == PRE_LAST);
        boundary_c   = tick_c && (idx_q == IDX_LAST);
        frame_done_d = boundary_c;

        if (tick_c) begin
            pre_cnt_d = '0;
            idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end

        // A load on the boundary bypasses the shadow; otherwise the shadow drains at the boundary.
        if (boundary_c) begin
            if (load) begin
                active_val_d = value;
                active_en_d  = digit_en;
            end else if (pending_q) begin
                active_val_d = shadow_val_q;
                active_en_d  = shadow_en_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            shadow_val_d = value;
            shadow_en_d  = digit_en;
            pending_d    = 1'b1;
        end

        an_d  = (pre_cnt_q == '0) ? '1 : ~(NUM_DIGITS'(1) << idx_q);
        seg_d = cur_blank_c ? 7'b1111111 : glyph(cur_nib_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q    <= '0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_en_q  <= '0;
            active_val_q <= '0;
            active_en_q  <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= 7'b1111111;
            an_q         <= '1;
        end else begin
            pre_cnt_q    <= pre_cnt_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_en_q  <= shadow_en_d;
            active_val_q <= active_val_d;
            active_en_q  <= active_en_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Scoreboard bench for seven_segment_scan_driver: a cycle-count reference model predicts
// each cycle's outputs, a separate monitor pops and compares them.
module tb_seven_segment_scan_driver;

    localparam int N = 4;
    localparam int S = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [4*N-1:0] value = '0;
    logic [N-1:0]  digit_en = '0;
    logic [6:0]    seg;
    logic [N-1:0]  an;
    logic          pending;
    logic          frame_done;

    seven_segment_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .digit_en(digit_en),
        .seg(seg), .an(an), .pending(pending), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [6:0] seg;
        logic [N-1:0] an;
        logic       pend;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    logic [6:0] glyph_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference state: cycles since reset plus the displayed/shadowed buffers.
    int          k;
    int unsigned m_val, s_val;
    logic [N-1:0] m_en, s_en;
    logic        m_pend;

    task automatic check(input string name, input int kk, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s k=%0d got=%0h expected=%0h", name, kk, got, exp);
        end
    endtask

    function automatic logic [6:0] model_seg(input int d);
        int unsigned upper;
        bit blank;
        upper = m_val >> (4 * d);
        blank = !m_en[d];
`ifdef SEVSEG_LZB_EN
        if (d > 0 && upper == 0) blank = 1'b1;
`endif
        return blank ? 7'b1111111 : glyph_tab[upper & 15];
    endfunction

    function automatic bit next_is_boundary();
        return (k % S == S - 1) && ((k / S) % N == N - 1);
    endfunction

    task automatic model_reset();
        k = 0; m_val = 0; s_val = 0; m_en = '0; s_en = '0; m_pend = 1'b0;
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic step(input logic ld, input logic [4*N-1:0] v, input logic [N-1:0] e);
        exp_t x;
        int pos, digit;
        bit bnd;
        @(negedge clk);
        load = ld; value = v; digit_en = e;
        pos   = k % S;
        digit = (k / S) % N;
        bnd   = (pos == S - 1) && (digit == N - 1);
        x.k   = k;
        x.an  = (pos == 0) ? '1 : N'(~(1 << digit));
        x.seg = model_seg(digit);
        x.fd  = bnd;
        if (bnd) begin
            if (ld) begin m_val = v; m_en = e; end
            else if (m_pend) begin m_val = s_val; m_en = s_en; end
            m_pend = 1'b0;
        end else if (ld) begin
            s_val = v; s_en = e; m_pend = 1'b1;
        end
        x.pend = m_pend;
        q.push_back(x);
        k++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_seg", -1, 32'(seg), 32'h7F);
        check("rst_an", -1, 32'(an), 32'(N'('1)));
        check("rst_pending", -1, 32'(pending), 0);
        check("rst_frame_done", -1, 32'(frame_done), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: every cycle the DUT presents a fresh output set, compare it with the queued prediction.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check("an", x.k, 32'(an), 32'(x.an));
                check("pending", x.k, 32'(pending), 32'(x.pend));
                check("frame_done", x.k, 32'(frame_done), 32'(x.fd));
                if (x.an != N'('1)) check("seg", x.k, 32'(seg), 32'(x.seg));
            end
        end
    end

    initial begin
        model_reset();
        do_reset();
        idle(20);
        step(1'b1, 16'h12AF, 4'b1111);
        idle(24);
        step(1'b1, 16'h1111, 4'b1111);
        step(1'b1, 16'h2222, 4'b1111);
        idle(24);
        while (!next_is_boundary()) step(1'b0, '0, '0);
        step(1'b1, 16'h3456, 4'b1111);
        idle(20);
        step(1'b1, 16'h8888, 4'b0101);
        idle(24);
        step(1'b1, 16'h0070, 4'b1111);
        idle(24);
        step(1'b1, 16'h0000, 4'b1111);
        idle(24);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0)
                step(1'b1, 16'($urandom), 4'($urandom));
            else
                step(1'b0, 16'($urandom), 4'($urandom));
        end
        // Mid-frame reset with data still shadowed: the shadow must be lost.
        idle(3);
        step(1'b1, 16'h9ABC, 4'b1111);
        idle(2);
        do_reset();
        idle(40);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0)
                step(1'b1, 16'($urandom), 4'($urandom));
            else
                step(1'b0, '0, '0);
        end
        @(posedge clk);
        #3;
        check("queue_drained", k, 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
